pack_compress_stream: RTL and testbench
=======================================

Name: pack_compress_stream

Overview:
- Streaming successor to the fixed 4-coefficient/10-bit ciphertext packer, parametrised on compression depth D.
- Accepts one coefficient per valid/ready beat, applies csubq, then Kyber compress_D.
- Collects GROUP=8 compressed values and emits one D-byte little-endian word per group.
- Tracks group position within each polynomial and vector; no divider IP; handles output backpressure.

Parameters:
- KYBER_Q, 3329, modulus.
- KYBER_N, 256, coefficients per polynomial.
- KYBER_K, 2, polynomials per vector.
- D, 10, compressed bits per coefficient; legal values 4, 5, 10, 11.
- COEFF_W, 12, input coefficient width.
- GROUP, 8, coefficients per output word (fixed, so that 8*D is a whole number of bytes).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of all state
- in_valid  in  1  coefficient valid
- in_ready  out  1  coefficient accepted when in_valid&&in_ready
- in_coeff  in  COEFF_W  coefficient, legal range [0, 2*KYBER_Q-1]
- out_valid  out  1  packed group valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_data  out  8*D  packed group; byte k = out_data[8k+7:8k]
- out_poly_last  out  1  with out_valid: last group of the current polynomial
- out_vec_last  out  1  with out_valid: last group of polynomial KYBER_K-1
- busy  out  1  slot count nonzero or out_valid

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock clk. All outputs, slots, counters and out_data reset to 0; in_ready resets to 1.
- clear: synchronous; same end state as reset; takes priority over any handshake in that cycle. A partial group is discarded.
- Per accepted coefficient x:
  - x' = (x >= Q) ? x-Q : x
  - c = (((x' << D) + Q/2) / Q) mod 2^D, Q/2 = 1664, integer floor.
  - Must be bit-exact for every x in [0, 2Q). Output for x >= 2Q is don't-care, but must not hang the block.
  - Either a single-cycle reciprocal-multiply or an exact division is acceptable; both must be exhaustively verified.
- Slot counter cnt runs 0..GROUP-1. Coefficient j of a group goes into out_data[D*j +: D], little-endian bit packing (Kyber byte order; byte 0 first on the wire).
- in_ready = (cnt != GROUP-1) || !out_valid || out_ready. Only the group-completing beat stalls; all other beats are accepted unconditionally.
- On acceptance with cnt == GROUP-1: the packed word (7 stored slots plus the new value) loads into the output register at that edge. cnt wraps to 0 and out_valid = 1 from the next cycle. Latency from the 8th accept to out_valid is 1 cycle.
- Output handshake:
  - out_valid holds until out_valid&&out_ready.
  - out_data, out_poly_last and out_vec_last are stable while stalled.
  - A drain and a new group load in the same cycle leave out_valid at 1 with the new data (full throughput, 1 coefficient/cycle).
  - Drain with no load: out_valid falls next cycle.
- Group counter gcnt runs 0..N/8-1 and poly counter pcnt runs 0..K-1; both advance at group load.
  - out_poly_last = (gcnt == N/8-1) at load.
  - out_vec_last = out_poly_last && (pcnt == K-1).
  - Both counters wrap to 0 after the vector-last load.
- Reset mid-group: partial data is lost and no output is produced. Reset while out_valid: the word is dropped.
- in_valid low: no state change except output drain.

Test Plan:
- D=10, coefficients 0, 2, 832, 1665, 3328, 3330, 6657, 1 -> compressed 0, 1, 256, 512, 0, 0, 0(x'=3328), 0; out_valid exactly 1 cycle after the 8th accept.
- D=10, eight coefficients of 2 -> out_data = 0x00_40_10_04_01_00_40_10_04_01 (byte9..byte0).
- D=4, x=1665 in all slots -> each nibble 8, out_data=0x88888888; D=11, x=1665 -> slot value 1024.
- Backpressure: out_ready=0 for 20 cycles with continuous in_valid -> 7 further accepts, then in_ready=0 on the 8th; first word held stable; out_ready=1 -> both words delivered in order, no loss or duplication.
- Full vector, K=2, N=256 streamed at 1/cycle with out_ready=1 -> 64 words; out_poly_last on words 31 and 63; out_vec_last only on word 63; counters back at 0.
- clear after 5 accepts, and separately async reset_n pulse while out_valid -> all outputs 0, in_ready=1; the next 8 coefficients form a fresh group at slot 0.
- Exhaustive sweep of x over 0..6657 for D in {4,5,10,11}, checked against a software model of compress_D(csubq(x)).

Source files
------------

// File: rtl/pack_compress_stream_if.sv
// Coefficient-in / packed-group-out handshake bundle for pack_compress_stream.
interface pack_compress_stream_if #(
  parameter int D       = 10,
  parameter int COEFF_W = 12
);
  logic               in_valid;
  logic               in_ready;
  logic [COEFF_W-1:0] in_coeff;
  logic               out_valid;
  logic               out_ready;
  logic [8*D-1:0]     out_data;
  logic               out_poly_last;
  logic               out_vec_last;

  modport slave (
    input  in_valid, in_coeff, out_ready,
    output in_ready, out_valid, out_data, out_poly_last, out_vec_last
  );

  modport master (
    output in_valid, in_coeff, out_ready,
    input  in_ready, out_valid, out_data, out_poly_last, out_vec_last
  );
endinterface

// File: rtl/pack_compress_stream.sv
// Streaming Kyber csubq + compress_D packer: 8 coefficients per D-byte word,
// with polynomial/vector boundary flags and output backpressure.
module pack_compress_stream #(
  parameter int KYBER_Q = 3329,
  parameter int KYBER_N = 256,
  parameter int KYBER_K = 2,
  parameter int D       = 10,
  parameter int COEFF_W = 12,
  parameter int GROUP   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  pack_compress_stream_if.slave  io,
  output logic                   busy
);
  localparam int GW   = GROUP * D;
  localparam int NGRP = KYBER_N / GROUP;
  localparam int GCW  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int PCW  = (KYBER_K > 1) ? $clog2(KYBER_K) : 1;
  localparam int CW   = $clog2(GROUP);
  // floor(2^32/Q): quotient estimate is low by at most one, fixed by one compare
  localparam logic [63:0] RECIP = 64'((64'd1 << 32) / KYBER_Q);

  logic [COEFF_W-1:0] xr;
  logic [63:0]        num, prod, qe, rem;
  logic [D-1:0]       cval;

  always_comb begin
    xr   = (io.in_coeff >= COEFF_W'(KYBER_Q)) ? io.in_coeff - COEFF_W'(KYBER_Q)
                                              : io.in_coeff;
    num  = (64'(xr) << D) + 64'(KYBER_Q / 2);
    prod = num * RECIP;
    qe   = prod >> 32;
    rem  = num - qe * 64'(KYBER_Q);
    if (rem >= 64'(KYBER_Q)) qe = qe + 64'd1;
    cval = qe[D-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{prod[31:0], qe[63:D]};

  logic [GROUP-2:0][D-1:0] slot;
  logic [CW-1:0]           cnt;
  logic [GCW-1:0]          gcnt;
  logic [PCW-1:0]          pcnt;
  logic                    out_valid_q, poly_last_q, vec_last_q;
  logic [GW-1:0]           out_data_q;

  logic last_slot, accept, drain, poly_end, vec_end;
  logic [GW-1:0] word;

  assign last_slot = (cnt == CW'(GROUP - 1));
  assign io.in_ready = !last_slot || !out_valid_q || io.out_ready;
  assign accept   = io.in_valid && io.in_ready;
  assign drain    = out_valid_q && io.out_ready;
  assign poly_end = (gcnt == GCW'(NGRP - 1));
  assign vec_end  = poly_end && (pcnt == PCW'(KYBER_K - 1));
  // slot 0 sits in the low bits, so the stored slots concatenate straight in
  assign word     = {cval, slot};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot        <= '0;
      cnt         <= '0;
      gcnt        <= '0;
      pcnt        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      poly_last_q <= 1'b0;
      vec_last_q  <= 1'b0;
    end else if (clear) begin
      slot        <= '0;
      cnt         <= '0;
      gcnt        <= '0;
      pcnt        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      poly_last_q <= 1'b0;
      vec_last_q  <= 1'b0;
    end else begin
      if (drain) out_valid_q <= 1'b0;
      if (accept) begin
        if (last_slot) begin
          cnt         <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= word;
          poly_last_q <= poly_end;
          vec_last_q  <= vec_end;
          if (poly_end) begin
            gcnt <= '0;
            pcnt <= vec_end ? '0 : pcnt + PCW'(1);
          end else begin
            gcnt <= gcnt + GCW'(1);
          end
        end else begin
          slot[cnt] <= cval;
          cnt       <= cnt + CW'(1);
        end
      end
    end
  end

  assign io.out_valid     = out_valid_q;
  assign io.out_data      = out_data_q;
  assign io.out_poly_last = poly_last_q;
  assign io.out_vec_last  = vec_last_q;
  assign busy             = (cnt != '0) || out_valid_q;
endmodule

// File: tb/tb_pack_compress_stream.sv
// Runs four packers (D = 4, 5, 10, 11) on one shared stream against a
// queue-based model of compress_D(csubq(x)) and 8-value grouping.
module tb_pack_compress_stream;
  localparam int Q  = 3329;
  localparam int CW = 13;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic reset_n, clear, in_valid, out_ready;
  logic [CW-1:0] in_coeff;
  logic [87:0] odata [NL];
  logic ovalid [NL], iready [NL], plast [NL], vlast [NL], bsy [NL];

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int DL = (g == 0) ? 4 : (g == 1) ? 5 : (g == 2) ? 10 : 11;
    pack_compress_stream_if #(.D(DL), .COEFF_W(CW)) ifc ();
    assign ifc.in_valid  = in_valid;
    assign ifc.in_coeff  = in_coeff;
    assign ifc.out_ready = out_ready;
    pack_compress_stream #(.D(DL), .COEFF_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .io(ifc), .busy(bsy[g])
    );
    assign odata[g]  = 88'(ifc.out_data);
    assign ovalid[g] = ifc.out_valid;
    assign iready[g] = ifc.in_ready;
    assign plast[g]  = ifc.out_poly_last;
    assign vlast[g]  = ifc.out_vec_last;
  end

  function automatic int dval(int i);
    case (i)
      0: return 4;
      1: return 5;
      2: return 10;
      default: return 11;
    endcase
  endfunction

  function automatic int comp(int x, int d);
    int xp;
    xp = (x >= Q) ? x - Q : x;
    return (((xp << d) + Q / 2) / Q) % (1 << d);
  endfunction

  // reference model state
  int          grp [NL][$];
  bit          mfull [NL];
  logic [87:0] mword [NL];
  bit          mpl [NL], mvl [NL];
  int          gidx [NL];
  int          nout [NL];
  bit          pl_log [$], vl_log [$];
  bit          acc_flag;

  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (!reset_n) begin
        vectors++;
        if (ovalid[i] !== 1'b0 || iready[i] !== 1'b1 || bsy[i] !== 1'b0 ||
            odata[i] !== '0 || plast[i] !== 1'b0 || vlast[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_state lane%0d: valid=%b ready=%b busy=%b data=%h, want 0 1 0 0",
                   i, ovalid[i], iready[i], bsy[i], odata[i]);
        end
        grp[i].delete(); mfull[i] = 0; mword[i] = '0; mpl[i] = 0; mvl[i] = 0; gidx[i] = 0;
        acc_flag = 0;
      end else begin
        bit er;
        er = (grp[i].size() != 7) || !mfull[i] || out_ready;
        vectors++;
        if (iready[i] !== er) begin
          miscompares++;
          $display("FAIL in_ready lane%0d: got %b want %b", i, iready[i], er);
        end
        vectors++;
        if (ovalid[i] !== mfull[i]) begin
          miscompares++;
          $display("FAIL out_valid lane%0d: got %b want %b", i, ovalid[i], mfull[i]);
        end
        vectors++;
        if (bsy[i] !== ((grp[i].size() != 0) || mfull[i])) begin
          miscompares++;
          $display("FAIL busy lane%0d: got %b want %b", i, bsy[i], (grp[i].size() != 0) || mfull[i]);
        end
        if (mfull[i]) begin
          vectors++;
          if (odata[i] !== mword[i] || plast[i] !== mpl[i] || vlast[i] !== mvl[i]) begin
            miscompares++;
            $display("FAIL out_word lane%0d: got %h pl=%b vl=%b want %h pl=%b vl=%b",
                     i, odata[i], plast[i], vlast[i], mword[i], mpl[i], mvl[i]);
          end
        end
        if (clear) begin
          grp[i].delete(); mfull[i] = 0; mword[i] = '0; mpl[i] = 0; mvl[i] = 0; gidx[i] = 0;
          acc_flag = 0;
        end else begin
          if (mfull[i] && out_ready) begin
            mfull[i] = 0;
            nout[i]++;
            if (i == 2) begin pl_log.push_back(plast[2]); vl_log.push_back(vlast[2]); end
          end
          if (in_valid && er) begin
            grp[i].push_back(comp(int'(in_coeff), dval(i)));
            if (grp[i].size() == 8) begin
              mword[i] = '0;
              for (int j = 0; j < 8; j++)
                mword[i] = mword[i] | (88'(grp[i][j]) << (dval(i) * j));
              mpl[i] = (gidx[i] % 32) == 31;
              mvl[i] = (gidx[i] % 64) == 63;
              gidx[i]++;
              mfull[i] = 1;
              grp[i].delete();
            end
          end
          if (i == 2) acc_flag = in_valid && er;
        end
      end
    end
  end

  task automatic send(input int x);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_coeff = CW'(x);
    do begin
      @(posedge clk); #1;
      t++;
      if (!acc_flag && t > 1) out_ready = 1'b1;
    end while (!acc_flag && t < 50);
    vectors++;
    if (!acc_flag) begin
      miscompares++;
      $display("FAIL accept_timeout: coeff %0d not accepted after %0d cycles, want accept", x, t);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NL; i++) begin
      vectors++;
      if (ovalid[i] !== 1'b0 || iready[i] !== 1'b1 || bsy[i] !== 1'b0 || odata[i] !== '0) begin
        miscompares++;
        $display("FAIL test_reset lane%0d: valid=%b ready=%b busy=%b data=%h", i, ovalid[i], iready[i], bsy[i], odata[i]);
      end
    end
  endtask

  task automatic test_vector_d10();
    int cs [8] = '{0, 2, 832, 1665, 3328, 3330, 6657, 1};
    logic [87:0] exp;
    do_reset();
    exp = (88'd1 << 10) | (88'd256 << 20) | (88'd512 << 30);
    for (int k = 0; k < 7; k++) send(cs[k]);
    vectors++;
    if (ovalid[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL d10_early_valid: got %b want 0", ovalid[2]);
    end
    send(cs[7]);
    vectors++;
    if (ovalid[2] !== 1'b1 || odata[2] !== exp) begin
      miscompares++;
      $display("FAIL d10_vector: valid=%b data=%h want 1 %h", ovalid[2], odata[2], exp);
    end
    idle(2);
  endtask

  task automatic test_patterns();
    logic [87:0] e11;
    do_reset();
    for (int k = 0; k < 8; k++) send(2);
    vectors++;
    if (odata[2] !== 88'h0040100401_0040100401) begin
      miscompares++;
      $display("FAIL d10_all_twos: got %h want 0040100401_0040100401", odata[2]);
    end
    for (int k = 0; k < 8; k++) send(1665);
    e11 = '0;
    for (int j = 0; j < 8; j++) e11 = e11 | (88'd1024 << (11 * j));
    vectors++;
    if (odata[0] !== 88'h88888888) begin
      miscompares++;
      $display("FAIL d4_1665: got %h want 88888888", odata[0]);
    end
    vectors++;
    if (odata[3] !== e11) begin
      miscompares++;
      $display("FAIL d11_1665: got %h want %h", odata[3], e11);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [87:0] held;
    int acc, n0, t;
    do_reset();
    out_ready = 1'b0;
    acc = 0;
    held = '0;
    n0 = nout[2];
    for (int k = 1; k <= 20; k++) begin
      in_valid = 1'b1;
      in_coeff = CW'($urandom_range(0, 2 * Q - 1));
      @(posedge clk); #1;
      if (acc_flag) acc++;
      if (k == 8) begin
        held = odata[2];
        vectors++;
        if (ovalid[2] !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_first_word: valid=%b want 1", ovalid[2]);
        end
      end else if (k > 8) begin
        vectors++;
        if (odata[2] !== held || ovalid[2] !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_stable: data=%h valid=%b want %h 1", odata[2], ovalid[2], held);
        end
      end
    end
    vectors++;
    if (acc != 15 || iready[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall: accepts=%0d in_ready=%b want 15 0", acc, iready[2]);
    end
    out_ready = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!acc_flag && t < 5);
    in_valid = 1'b0;
    idle(3);
    vectors++;
    if (nout[2] - n0 != 2 || ovalid[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: words=%0d valid=%b want 2 0", nout[2] - n0, ovalid[2]);
    end
  endtask

  task automatic test_full_vector();
    int npl, nvl;
    do_reset();
    pl_log.delete(); vl_log.delete();
    for (int k = 0; k < 512; k++) send($urandom_range(0, 2 * Q - 1));
    idle(3);
    npl = 0; nvl = 0;
    foreach (pl_log[k]) begin npl += pl_log[k]; nvl += vl_log[k]; end
    vectors++;
    if (pl_log.size() != 64) begin
      miscompares++;
      $display("FAIL vec_words: got %0d want 64", pl_log.size());
    end else begin
      vectors++;
      if (pl_log[31] !== 1'b1 || vl_log[31] !== 1'b0 || pl_log[63] !== 1'b1 || vl_log[63] !== 1'b1) begin
        miscompares++;
        $display("FAIL vec_flags: w31 pl=%b vl=%b w63 pl=%b vl=%b want 1 0 1 1", pl_log[31], vl_log[31], pl_log[63], vl_log[63]);
      end
    end
    vectors++;
    if (npl != 2 || nvl != 1 || bsy[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL vec_counts: poly_last=%0d vec_last=%0d busy=%b want 2 1 0", npl, nvl, bsy[2]);
    end
    // counters should have wrapped: next word is group 0 with no flags
    for (int k = 0; k < 8; k++) send($urandom_range(0, 2 * Q - 1));
    vectors++;
    if (plast[2] !== 1'b0 || vlast[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL vec_wrap: pl=%b vl=%b want 0 0", plast[2], vlast[2]);
    end
    idle(2);
  endtask

  task automatic check_fresh_group(input string tag);
    int cs [8];
    logic [87:0] exp;
    exp = '0;
    for (int k = 0; k < 8; k++) begin
      cs[k] = $urandom_range(0, 2 * Q - 1);
      exp = exp | (88'(comp(cs[k], 10)) << (10 * k));
      send(cs[k]);
    end
    vectors++;
    if (ovalid[2] !== 1'b1 || odata[2] !== exp) begin
      miscompares++;
      $display("FAIL %s_fresh_group: valid=%b data=%h want 1 %h", tag, ovalid[2], odata[2], exp);
    end
    idle(2);
  endtask

  task automatic test_clear_and_reset();
    do_reset();
    for (int k = 0; k < 5; k++) send($urandom_range(0, 2 * Q - 1));
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int i = 0; i < NL; i++) begin
      vectors++;
      if (ovalid[i] !== 1'b0 || iready[i] !== 1'b1 || bsy[i] !== 1'b0 || odata[i] !== '0) begin
        miscompares++;
        $display("FAIL clear_state lane%0d: valid=%b ready=%b busy=%b data=%h", i, ovalid[i], iready[i], bsy[i], odata[i]);
      end
    end
    check_fresh_group("clear");
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send($urandom_range(0, 2 * Q - 1));
    vectors++;
    if (ovalid[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_valid: got %b want 1", ovalid[2]);
    end
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NL; i++) begin
      vectors++;
      if (ovalid[i] !== 1'b0 || iready[i] !== 1'b1 || bsy[i] !== 1'b0 || odata[i] !== '0) begin
        miscompares++;
        $display("FAIL async_reset lane%0d: valid=%b ready=%b busy=%b data=%h", i, ovalid[i], iready[i], bsy[i], odata[i]);
      end
    end
    @(negedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    check_fresh_group("reset");
  endtask

  task automatic test_sweep();
    do_reset();
    for (int x = 0; x < 2 * Q; x++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      out_ready = ($urandom_range(0, 3) != 0);
      send(x);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send(0);
    idle(3);
    for (int i = 0; i < NL; i++) begin
      vectors++;
      if (ovalid[i] !== 1'b0 || bsy[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_drain lane%0d: valid=%b busy=%b want 0 0", i, ovalid[i], bsy[i]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_coeff = '0;
    for (int i = 0; i < NL; i++) nout[i] = 0;
    test_reset();
    test_vector_d10();
    test_patterns();
    test_backpressure();
    test_full_vector();
    test_clear_and_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
